uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, meaning CLK cycles per serial bit (100 MHz / 115200 baud).
REQ-002 The module SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2, meaning cycles from the start-bit edge to its mid-bit check.
REQ-003 The module SHALL have port CLK, input, 1, the single system clock; all state is on its rising edge.
REQ-004 The module SHALL have port RST, input, 1, reset; RST is asynchronous and active-high.
REQ-005 The module SHALL have port RX, input, 1, serial line, idle high, asynchronous to CLK.
REQ-006 The module SHALL have port RD_ACK, input, 1, a one-cycle strobe from the MMIO read of the data address; it consumes the held byte.
REQ-007 The module SHALL have port DATA, output, 8, the last received byte, held stable until the next valid frame.
REQ-008 The module SHALL have port DATA_READY, output, 1, meaning an unconsumed byte is held in DATA.
REQ-009 The module SHALL have port RX_INT, output, 1, a one-cycle pulse per valid frame, for ORing into the MCU INTR.
REQ-010 The module SHALL have port FRAME_ERR, output, 1, a sticky flag meaning a stop bit was sampled low.
REQ-011 The module SHALL have port OVERRUN, output, 1, a sticky flag meaning a byte was overwritten before it was consumed.

Function
REQ-012 RX SHALL pass through a 2-flop synchronizer reset to 1; all logic SHALL use only the synchronized value.
REQ-013 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, with a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-015 IDLE: a synchronized RX of 0 SHALL enter START with the counter cleared.
REQ-016 START: after HALF_BIT cycles, if RX is 0 the FSM SHALL enter DATA with the counter cleared; otherwise it SHALL treat the event as a glitch, return to IDLE and set no flags.
REQ-017 DATA: every CLKS_PER_BIT cycles the FSM SHALL sample RX into the shift register at the index position; after index 7 it SHALL enter STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles the FSM SHALL sample RX and always return to IDLE in the next cycle, so back-to-back frames are received.
REQ-019 Stop sample 1: DATA SHALL load the shift register, DATA_READY SHALL be set, and RX_INT SHALL pulse high for exactly 1 cycle.
REQ-020 Stop sample 0: FRAME_ERR SHALL be set, and DATA, DATA_READY and RX_INT SHALL remain unchanged.
REQ-021 RD_ACK SHALL clear DATA_READY, FRAME_ERR and OVERRUN in the next cycle.
REQ-022 A valid frame completing while DATA_READY=1 with no RD_ACK SHALL overwrite DATA, keep DATA_READY=1, set OVERRUN and pulse RX_INT.
REQ-023 When RD_ACK coincides with a valid frame completing, the new byte SHALL win: DATA_READY=1, DATA=new byte, OVERRUN=0, FRAME_ERR=0.
REQ-024 RD_ACK in any FSM state SHALL NOT disturb reception in progress.
REQ-025 Latency: DATA_READY SHALL rise between 9.5*CLKS_PER_BIT and 9.5*CLKS_PER_BIT+4 cycles after the RX pin falls for a start bit.
REQ-026 RX held low continuously SHALL yield one frame with FRAME_ERR set, after which the FSM stays in IDLE until RX returns high and falls again.

Reset
REQ-027 While RST=1, the FSM SHALL be in IDLE, counters 0, DATA=8'h00, DATA_READY=0, RX_INT=0, FRAME_ERR=0, OVERRUN=0, and the synchronizer at 1.
REQ-028 RST asserted mid-frame SHALL abort the frame with no output change beyond reset values; after RST falls, reception SHALL begin only on a new falling edge of RX.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-029 Send 8'hA5 as a valid frame -> DATA=8'hA5, DATA_READY=1, one RX_INT pulse, rise within 152..156 cycles of the start edge.
REQ-030 Send 8'h3C then 8'hC3 back-to-back with no RD_ACK -> DATA=8'hC3, OVERRUN=1, two RX_INT pulses; RD_ACK -> DATA_READY=0, OVERRUN=0.
REQ-031 Send 8'h55 with the stop bit driven 0 -> FRAME_ERR=1, DATA_READY=0, DATA unchanged, no RX_INT.
REQ-032 Drive a 4-cycle low glitch on RX -> no state change visible on any output; a following valid 8'h0F is received correctly.
REQ-033 Pulse RD_ACK in the same cycle the 8'h81 stop bit is sampled, with a prior byte pending -> DATA=8'h81, DATA_READY=1, OVERRUN=0.
REQ-034 Assert RST during bit 3 of a frame, release it, then send 8'hFE -> outputs are at reset values after RST, then DATA=8'hFE with no FRAME_ERR.

Source files
------------

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//
// Purpose : Host-side register interface of the UART receiver. The receiver
//           presents the received byte and its status flags; the host
//           acknowledges consumption of the byte with a one-cycle strobe
//           generated by the MMIO read of the data address.
//
// Signals :
//   RD_ACK      host -> uart  one-cycle strobe, consumes the held byte
//   DATA[7:0]   uart -> host  last received byte, stable until the next
//                             valid frame
//   DATA_READY  uart -> host  an unconsumed byte is held in DATA
//   RX_INT      uart -> host  one-cycle pulse per valid frame
//   FRAME_ERR   uart -> host  sticky, a stop bit was sampled low
//   OVERRUN     uart -> host  sticky, a byte was overwritten unconsumed
//
// Modports:
//   master  host / MCU side (drives RD_ACK)
//   slave   receiver side (drives data and status)
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic       RD_ACK;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       RX_INT;
    logic       FRAME_ERR;
    logic       OVERRUN;

    modport master (
        output RD_ACK,
        input  DATA,
        input  DATA_READY,
        input  RX_INT,
        input  FRAME_ERR,
        input  OVERRUN
    );

    modport slave (
        input  RD_ACK,
        output DATA,
        output DATA_READY,
        output RX_INT,
        output FRAME_ERR,
        output OVERRUN
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Purpose : 8N1 UART receiver with a one-byte holding register, a one-cycle
//           receive interrupt pulse and sticky framing-error / overrun flags.
//           The start bit is qualified at its middle (HALF_BIT cycles after
//           the edge); every following bit is sampled one full bit period
//           later, i.e. near its centre.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit
//   HALF_BIT      cycles from the start-bit edge to the start-bit check
//
// Ports   :
//   CLK   input   system clock, all state on the rising edge
//   RST   input   asynchronous, active-high reset
//   RX    input   serial line, idle high, asynchronous to CLK
//   bus   slave   host interface (RD_ACK in; DATA, DATA_READY, RX_INT,
//                 FRAME_ERR, OVERRUN out)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     RX,
    uart_rx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_armed;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_int;
    logic             r_fe;
    logic             r_ov;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_idx_next;
    logic [7:0]       w_shift_next;
    logic             w_armed_next;
    logic [7:0]       w_data_next;
    logic             w_ready_next;
    logic             w_int_next;
    logic             w_fe_next;
    logic             w_ov_next;

    logic             w_bit_done;
    logic             w_half_done;

    assign w_bit_done  = (r_cnt == BIT_LAST);
    assign w_half_done = (r_cnt == HALF_LAST);

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Both stages reset to the idle (high) level so a
    // reset release never looks like a falling edge on a quiet line.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_armed <= 1'b1;
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_int   <= 1'b0;
            r_fe    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_armed <= w_armed_next;
            r_data  <= w_data_next;
            r_ready <= w_ready_next;
            r_int   <= w_int_next;
            r_fe    <= w_fe_next;
            r_ov    <= w_ov_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_armed_next = r_armed;
        w_data_next  = r_data;
        w_ready_next = r_ready;
        w_int_next   = 1'b0;
        w_fe_next    = r_fe;
        w_ov_next    = r_ov;

        // A host read clears the status; a frame completing in the same
        // cycle is applied afterwards so the new byte wins.
        if (bus.RD_ACK) begin
            w_ready_next = 1'b0;
            w_fe_next    = 1'b0;
            w_ov_next    = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_idx_next = 3'd0;
                // A start needs a high-to-low transition: after a frame that
                // ended with the line stuck low, the line must first return
                // high before another frame can begin.
                if (!r_rx_sync && r_armed) begin
                    w_state_next = ST_START;
                    w_armed_next = 1'b0;
                end else if (r_rx_sync) begin
                    w_armed_next = 1'b1;
                end
            end

            ST_START: begin
                if (w_half_done) begin
                    w_cnt_next = '0;
                    // Line back high at mid start bit: a glitch, no flags.
                    if (!r_rx_sync) begin
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = r_rx_sync;
                    if (r_idx == 3'd7) begin
                        w_idx_next   = 3'd0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    // Leave at the centre of the stop bit so the next start
                    // edge, half a bit later, is seen from IDLE.
                    w_state_next = ST_IDLE;
                    if (r_rx_sync) begin
                        w_data_next  = r_shift;
                        w_ready_next = 1'b1;
                        w_int_next   = 1'b1;
                        if (r_ready && !bus.RD_ACK) begin
                            w_ov_next = 1'b1;
                        end
                    end else begin
                        w_fe_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_idx_next   = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.DATA       = r_data;
    assign bus.DATA_READY = r_ready;
    assign bus.RX_INT     = r_int;
    assign bus.FRAME_ERR  = r_fe;
    assign bus.OVERRUN    = r_ov;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx at 16 clocks per bit. A byte-level model of the
// host-visible registers is updated once per frame / read, and a compare
// process checks every DUT output against it on every cycle outside the short
// window in which a frame completes.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int HB  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RX  = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HB)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .RX  (RX),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Model of the host-visible state
    logic [7:0] m_data  = 8'h00;
    bit         m_ready = 1'b0;
    bit         m_fe    = 1'b0;
    bit         m_ov    = 1'b0;
    int         m_ints  = 0;
    bit         hold    = 1'b0;

    int tests = 0;
    int fails = 0;

    int   cyc            = 0;
    int   int_cycles     = 0;
    int   int_rises      = 0;
    int   ready_rise_cyc = -1;
    logic prev_int       = 1'b0;
    logic prev_ready     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare, 1 time unit after the active edge
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (bus.RX_INT === 1'b1) int_cycles++;
        if (bus.RX_INT === 1'b1 && prev_int !== 1'b1) int_rises++;
        if (bus.DATA_READY === 1'b1 && prev_ready !== 1'b1) ready_rise_cyc = cyc;
        prev_int   = bus.RX_INT;
        prev_ready = bus.DATA_READY;
        if (!hold) begin
            chk("cyc_DATA",       {24'h0, bus.DATA},       {24'h0, m_data});
            chk("cyc_DATA_READY", {31'h0, bus.DATA_READY}, {31'h0, m_ready});
            chk("cyc_FRAME_ERR",  {31'h0, bus.FRAME_ERR},  {31'h0, m_fe});
            chk("cyc_OVERRUN",    {31'h0, bus.OVERRUN},    {31'h0, m_ov});
            chk("cyc_RX_INT",     {31'h0, bus.RX_INT},     32'h0);
        end
    end

    task automatic ack_pulse();
        @(negedge CLK);
        bus.RD_ACK = 1'b1;
        m_ready    = 1'b0;
        m_fe       = 1'b0;
        m_ov       = 1'b0;
        @(negedge CLK);
        bus.RD_ACK = 1'b0;
    endtask

    // One frame on RX. The stop bit starts 144 cycles after the start edge;
    // its centre (as seen through the synchronizer) is 154.5 cycles after
    // the pin falls, which is where an acknowledge can be made to coincide.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                              input bit ack_at_stop, output int start_cyc);
        @(negedge CLK);
        RX        = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RX   = stop_bit;
        hold = 1'b1;
        repeat (10) @(negedge CLK);
        if (ack_at_stop) bus.RD_ACK = 1'b1;
        @(negedge CLK);
        bus.RD_ACK = 1'b0;
        repeat (CPB - 11) @(negedge CLK);
        if (stop_bit) begin
            if (ack_at_stop) begin
                m_ov = 1'b0;
                m_fe = 1'b0;
            end else if (m_ready) begin
                m_ov = 1'b1;
            end
            m_data  = b;
            m_ready = 1'b1;
            m_ints++;
        end else begin
            m_fe = 1'b1;
        end
        RX   = 1'b1;
        hold = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int ints0;
        bus.RD_ACK = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_DATA",       {24'h0, bus.DATA},       32'h00);
        chk("rst_DATA_READY", {31'h0, bus.DATA_READY}, 32'h0);
        chk("rst_RX_INT",     {31'h0, bus.RX_INT},     32'h0);
        chk("rst_FRAME_ERR",  {31'h0, bus.FRAME_ERR},  32'h0);
        chk("rst_OVERRUN",    {31'h0, bus.OVERRUN},    32'h0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Single valid frame with latency window
        send_frame(8'hA5, 1'b1, 1'b0, s);
        chk("a5_DATA",       {24'h0, bus.DATA},       32'hA5);
        chk("a5_DATA_READY", {31'h0, bus.DATA_READY}, 32'h1);
        chk("a5_int_count",  int_rises,               32'd1);
        chk("a5_lat_min", {31'h0, (ready_rise_cyc - s) >= 152}, 32'h1);
        chk("a5_lat_max", {31'h0, (ready_rise_cyc - s) <= 156}, 32'h1);
        ack_pulse();
        repeat (20) @(negedge CLK);

        // Back-to-back frames without a read -> overrun
        ints0 = int_rises;
        send_frame(8'h3C, 1'b1, 1'b0, s);
        send_frame(8'hC3, 1'b1, 1'b0, s);
        chk("b2b_DATA",      {24'h0, bus.DATA},    32'hC3);
        chk("b2b_OVERRUN",   {31'h0, bus.OVERRUN}, 32'h1);
        chk("b2b_int_count", int_rises - ints0,    32'd2);
        ack_pulse();
        chk("b2b_ack_READY",   {31'h0, bus.DATA_READY}, 32'h0);
        chk("b2b_ack_OVERRUN", {31'h0, bus.OVERRUN},    32'h0);
        repeat (20) @(negedge CLK);

        // Stop bit low -> framing error, byte discarded
        ints0 = int_rises;
        send_frame(8'h55, 1'b0, 1'b0, s);
        chk("fe_FRAME_ERR",  {31'h0, bus.FRAME_ERR},  32'h1);
        chk("fe_DATA_READY", {31'h0, bus.DATA_READY}, 32'h0);
        chk("fe_DATA",       {24'h0, bus.DATA},       32'hC3);
        chk("fe_int_count",  int_rises - ints0,       32'd0);
        repeat (40) @(negedge CLK);
        ack_pulse();
        repeat (20) @(negedge CLK);

        // Short low glitch is ignored, next frame received
        @(negedge CLK);
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        RX = 1'b1;
        repeat (40) @(negedge CLK);
        send_frame(8'h0F, 1'b1, 1'b0, s);
        chk("glitch_DATA",      {24'h0, bus.DATA},       32'h0F);
        chk("glitch_FRAME_ERR", {31'h0, bus.FRAME_ERR},  32'h0);
        ack_pulse();
        repeat (20) @(negedge CLK);

        // Read coinciding with the stop sample of a new frame
        send_frame(8'h11, 1'b1, 1'b0, s);
        send_frame(8'h81, 1'b1, 1'b1, s);
        chk("coinc_DATA",       {24'h0, bus.DATA},       32'h81);
        chk("coinc_DATA_READY", {31'h0, bus.DATA_READY}, 32'h1);
        chk("coinc_OVERRUN",    {31'h0, bus.OVERRUN},    32'h0);
        ack_pulse();
        repeat (20) @(negedge CLK);

        // Line held low: exactly one errored frame, then silence
        ints0 = int_rises;
        @(negedge CLK);
        RX = 1'b0;
        repeat (144) @(negedge CLK);
        hold = 1'b1;
        repeat (26) @(negedge CLK);
        m_fe = 1'b1;
        hold = 1'b0;
        repeat (300) @(negedge CLK);
        chk("low_FRAME_ERR", {31'h0, bus.FRAME_ERR}, 32'h1);
        chk("low_int_count", int_rises - ints0,      32'd0);
        RX = 1'b1;
        repeat (40) @(negedge CLK);
        ack_pulse();
        send_frame(8'h5A, 1'b1, 1'b0, s);
        chk("low_after_DATA", {24'h0, bus.DATA}, 32'h5A);
        repeat (20) @(negedge CLK);

        // Reset during bit 3, then a clean frame
        ints0 = int_rises;
        @(negedge CLK);
        RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            RX = i[0];
            repeat (CPB) @(negedge CLK);
        end
        RX = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        RST     = 1'b1;
        RX      = 1'b1;
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_rst_DATA",       {24'h0, bus.DATA},       32'h00);
        chk("mid_rst_DATA_READY", {31'h0, bus.DATA_READY}, 32'h0);
        RST = 1'b0;
        repeat (200) @(negedge CLK);
        chk("mid_rst_int_count", int_rises - ints0, 32'd0);
        send_frame(8'hFE, 1'b1, 1'b0, s);
        chk("post_rst_DATA",      {24'h0, bus.DATA},      32'hFE);
        chk("post_rst_FRAME_ERR", {31'h0, bus.FRAME_ERR}, 32'h0);
        repeat (10) @(negedge CLK);

        // Every interrupt pulse was one cycle wide and matched a frame
        chk("int_width",       int_cycles, int_rises);
        chk("int_total_model", int_rises,  m_ints);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
